// File: rtl/iomem_gpio_bank.sv
// iomem_gpio_bank: memory-mapped GPIO bank on the PicoSoC iomem bus.
// NUM_GPIO channels with output, output-enable, pull-up/pull-down control,
// a synchronised and debounced input, and sticky edge-interrupt status
// feeding a single registered level IRQ.
module iomem_gpio_bank #(
  parameter int         NUM_GPIO     = 8,
  parameter logic [7:0] BASE_SEL     = 8'h07,
  parameter int         SYNC_STAGES  = 2,
  parameter int         DEBOUNCE_DIV = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic [NUM_GPIO-1:0] gpio_pu,
  output logic [NUM_GPIO-1:0] gpio_pd,
  output logic                irq
);

  localparam int N = NUM_GPIO;
  localparam int unsigned NS = SYNC_STAGES;

  typedef logic [N-1:0] vec_t;

  // Register offsets within the block
  typedef enum logic [7:0] {
    OFF_OUT     = 8'h00,
    OFF_OE      = 8'h04,
    OFF_IN      = 8'h08,
    OFF_PU      = 8'h0C,
    OFF_PD      = 8'h10,
    OFF_RISE_EN = 8'h14,
    OFF_FALL_EN = 8'h18,
    OFF_STATUS  = 8'h1C,
    OFF_OUT_SET = 8'h20,
    OFF_OUT_CLR = 8'h24
  } reg_off_e;

  logic       sel;
  logic       is_write;
  logic [7:0] off;
  vec_t       wsel;
  vec_t       wbits;

  vec_t out_r, oe_r, pu_r, pd_r, rise_en_r, fall_en_r, status_r;
  vec_t in_r, in_d;
  vec_t hist0, hist1;
  vec_t sync_q [NS];
  vec_t sync;
  vec_t stable;
  vec_t rise, fall;
  logic tick;

  logic we_out, we_oe, we_pu, we_pd, we_rise, we_fall, we_stat, we_set, we_clr;
  logic [31:0] rd_mux;

  // Upper address bits below the selector and unused data bits have no role here
  logic unused_bits;
  assign unused_bits = ^{iomem_addr[23:8], iomem_wdata};

  assign sel      = iomem_valid && (iomem_addr[31:24] == BASE_SEL) && !iomem_ready;
  assign is_write = |iomem_wstrb;
  assign off      = iomem_addr[7:0];
  assign sync     = sync_q[NS-1];

  // Per-bit write mask from byte strobes, limited to implemented channels
  always_comb begin
    wsel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      wsel[i] = iomem_wstrb[i/8];
    end
    wbits = iomem_wdata[N-1:0] & wsel;
  end

  // Decode per-register write enables for the selected transaction
  always_comb begin
    we_out  = 1'b0;
    we_oe   = 1'b0;
    we_pu   = 1'b0;
    we_pd   = 1'b0;
    we_rise = 1'b0;
    we_fall = 1'b0;
    we_stat = 1'b0;
    we_set  = 1'b0;
    we_clr  = 1'b0;
    if (sel && is_write) begin
      case (off)
        OFF_OUT:     we_out  = 1'b1;
        OFF_OE:      we_oe   = 1'b1;
        OFF_PU:      we_pu   = 1'b1;
        OFF_PD:      we_pd   = 1'b1;
        OFF_RISE_EN: we_rise = 1'b1;
        OFF_FALL_EN: we_fall = 1'b1;
        OFF_STATUS:  we_stat = 1'b1;
        OFF_OUT_SET: we_set  = 1'b1;
        OFF_OUT_CLR: we_clr  = 1'b1;
        default: ;
      endcase
    end
  end

  // Read mux: pre-write register contents, zero-extended; unmapped reads 0
  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_OUT:     rd_mux = 32'(out_r);
      OFF_OE:      rd_mux = 32'(oe_r);
      OFF_IN:      rd_mux = 32'(in_r);
      OFF_PU:      rd_mux = 32'(pu_r);
      OFF_PD:      rd_mux = 32'(pd_r);
      OFF_RISE_EN: rd_mux = 32'(rise_en_r);
      OFF_FALL_EN: rd_mux = 32'(fall_en_r);
      OFF_STATUS:  rd_mux = 32'(status_r);
      default:     rd_mux = '0;
    endcase
  end

  // Bus handshake: one-cycle ready pulse with registered read data
  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      iomem_ready <= sel;
      if (sel) begin
        iomem_rdata <= rd_mux;
      end
    end
  end

  // Control registers; only one offset is written per transaction
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_r     <= '0;
      oe_r      <= '0;
      pu_r      <= '0;
      pd_r      <= '0;
      rise_en_r <= '0;
      fall_en_r <= '0;
    end else begin
      if (we_out) begin
        out_r <= (out_r & ~wsel) | wbits;
      end else if (we_set) begin
        out_r <= out_r | wbits;
      end else if (we_clr) begin
        out_r <= out_r & ~wbits;
      end
      if (we_oe)   oe_r      <= (oe_r & ~wsel) | wbits;
      if (we_pu)   pu_r      <= (pu_r & ~wsel) | wbits;
      if (we_pd)   pd_r      <= (pd_r & ~wsel) | wbits;
      if (we_rise) rise_en_r <= (rise_en_r & ~wsel) | wbits;
      if (we_fall) fall_en_r <= (fall_en_r & ~wsel) | wbits;
    end
  end

  // Input synchroniser chain for asynchronous pads
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NS; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gpio_in;
      for (int unsigned i = 1; i < NS; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Debounce sample tick: free-running when no prescaling is requested
  generate
    if (DEBOUNCE_DIV <= 1) begin : g_nodiv
      assign tick = 1'b1;
    end else begin : g_div
      localparam int CW = $clog2(DEBOUNCE_DIV);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_DIV - 1);
      logic [CW-1:0] pre_cnt;

      assign tick = (pre_cnt == LAST);

      // Prescaler counts 0..DEBOUNCE_DIV-1 and wraps
      always_ff @(posedge clk) begin
        if (!resetn) begin
          pre_cnt <= '0;
        end else if (tick) begin
          pre_cnt <= '0;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end
    end
  endgenerate

  // Bits whose current sample agrees with both history samples
  assign stable = ~(sync ^ hist0) & ~(hist0 ^ hist1);

  // Debounce: IN follows sync only after three equal samples on ticks
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hist0 <= '0;
      hist1 <= '0;
      in_r  <= '0;
    end else if (tick) begin
      hist0 <= sync;
      hist1 <= hist0;
      in_r  <= (in_r & ~stable) | (sync & stable);
    end
  end

  assign rise = in_r & ~in_d & rise_en_r;
  assign fall = ~in_r & in_d & fall_en_r;

  // Edge history, sticky status (hardware set beats software clear) and IRQ
  always_ff @(posedge clk) begin
    if (!resetn) begin
      in_d     <= '0;
      status_r <= '0;
      irq      <= 1'b0;
    end else begin
      in_d     <= in_r;
      status_r <= (status_r & ~(we_stat ? wbits : '0)) | rise | fall;
      irq      <= |(status_r & (rise_en_r | fall_en_r));
    end
  end

  assign gpio_out = out_r;
  assign gpio_oe  = oe_r;
  assign gpio_pu  = pu_r;
  assign gpio_pd  = pd_r & ~pu_r;

endmodule

// File: tb/tb_iomem_gpio_bank.sv
// Directed scoreboard bench for iomem_gpio_bank: one instance without
// debounce prescaling (base 0x07) and one with DEBOUNCE_DIV=4 (base 0x08)
// sharing the bus.
module tb_iomem_gpio_bank;

  localparam logic [31:0] A0 = 32'h0700_0000;
  localparam logic [31:0] A4 = 32'h0800_0000;

  logic        clk;
  logic        resetn;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;

  logic        ready0, ready4;
  logic [31:0] rdata0, rdata4;
  logic [7:0]  gpio_in0, gpio_in4;
  logic [7:0]  out0, oe0, pu0, pd0;
  logic [7:0]  out4, oe4, pu4, pd4;
  logic        irq0, irq4;

  logic [31:0] sb [$];
  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  iomem_gpio_bank #(
    .NUM_GPIO    (8),
    .BASE_SEL    (8'h07),
    .SYNC_STAGES (2),
    .DEBOUNCE_DIV(0)
  ) dut0 (
    .clk        (clk),
    .resetn     (resetn),
    .iomem_valid(iomem_valid),
    .iomem_ready(ready0),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(rdata0),
    .gpio_in    (gpio_in0),
    .gpio_out   (out0),
    .gpio_oe    (oe0),
    .gpio_pu    (pu0),
    .gpio_pd    (pd0),
    .irq        (irq0)
  );

  iomem_gpio_bank #(
    .NUM_GPIO    (8),
    .BASE_SEL    (8'h08),
    .SYNC_STAGES (2),
    .DEBOUNCE_DIV(4)
  ) dut4 (
    .clk        (clk),
    .resetn     (resetn),
    .iomem_valid(iomem_valid),
    .iomem_ready(ready4),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(rdata4),
    .gpio_in    (gpio_in4),
    .gpio_out   (out4),
    .gpio_oe    (oe4),
    .gpio_pu    (pu4),
    .gpio_pd    (pd4),
    .irq        (irq4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic expect_v(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    if (sb.size() == 0) exp = 'x;
    else exp = sb.pop_front();
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic pin(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    expect_v(exp);
    check(tag, obs);
  endtask

  // Called at #1 after a rising edge; returns at #1 after the ready edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] r, output bit ok);
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wstrb = s;
    iomem_wdata = d;
    ok = 1'b0;
    r  = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if ((a[31:24] == 8'h07) ? ready0 : ready4) begin
        ok = 1'b1;
        r  = (a[31:24] == 8'h07) ? rdata0 : rdata4;
        break;
      end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
  endtask

  task automatic acc(input string tag, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input logic [31:0] exp);
    logic [31:0] r;
    bit ok;
    expect_v(exp);
    bus(a, s, d, r, ok);
    check(ok ? tag : {tag, " timeout"}, ok ? r : ~exp);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    acc(tag, a, 4'h0, 32'h0, exp);
  endtask

  initial begin
    int n;
    logic seen;
    resetn      = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr  = '0;
    iomem_wdata = '0;
    gpio_in0    = '0;
    gpio_in4    = '0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc(1);

    // Reset state
    pin("rst ready", 32'(ready0), 0);
    pin("rst rdata", rdata0, 0);
    pin("rst irq", 32'(irq0), 0);
    pin("rst out", 32'(out0), 0);
    pin("rst oe", 32'(oe0), 0);
    pin("rst pu", 32'(pu0), 0);
    pin("rst pd", 32'(pd0), 0);
    for (int o = 0; o <= 36; o += 4) begin
      rd($sformatf("rst rd %02h", o), A0 | 32'(o), 32'h0);
    end
    rd("unmapped rd 28", A0 | 32'h28, 32'h0);

    // OUT, OUT_SET, OUT_CLR with byte strobes
    acc("wr out", A0 | 32'h00, 4'b0001, 32'hFFFF_FFA5, 32'h0);
    pin("out a5", 32'(out0), 32'hA5);
    acc("wr out_set", A0 | 32'h20, 4'b0001, 32'h0A, 32'h0);
    pin("out af", 32'(out0), 32'hAF);
    acc("wr out_clr", A0 | 32'h24, 4'b0001, 32'h05, 32'h0);
    pin("out aa", 32'(out0), 32'hAA);
    rd("rd out", A0 | 32'h00, 32'h0000_00AA);
    acc("wr out hi bytes", A0 | 32'h00, 4'b1110, 32'hFFFF_FF00, 32'hAA);
    pin("out hi ignored", 32'(out0), 32'hAA);
    rd("rd out_set", A0 | 32'h20, 32'h0);
    rd("rd out again", A0 | 32'h00, 32'hAA);
    cyc(3);
    pin("rdata hold", rdata0, 32'hAA);
    acc("wr unmapped", A0 | 32'h30, 4'hF, 32'hFFFF_FFFF, 32'h0);
    rd("rd unmapped 30", A0 | 32'h30, 32'h0);

    // Pulls and output enable
    acc("wr pu", A0 | 32'h0C, 4'hF, 32'hFFFF_FF0F, 32'h0);
    acc("wr pd", A0 | 32'h10, 4'b0001, 32'h3C, 32'h0);
    pin("gpio_pu", 32'(pu0), 32'h0F);
    pin("gpio_pd", 32'(pd0), 32'h30);
    rd("rd pd", A0 | 32'h10, 32'h3C);
    rd("rd pu", A0 | 32'h0C, 32'h0F);
    acc("wr oe", A0 | 32'h04, 4'b0001, 32'h5A, 32'h0);
    pin("gpio_oe", 32'(oe0), 32'h5A);

    // Rising edge on channel 0: pad -> irq in SYNC_STAGES+3+2 cycles
    acc("wr rise_en", A0 | 32'h14, 4'b0001, 32'h01, 32'h0);
    cyc(2);
    gpio_in0[0] = 1'b1;
    n = 0;
    while (!irq0 && n < 20) begin
      cyc(1);
      n++;
    end
    pin("irq latency", 32'(n), 32'd7);
    rd("rd in rise", A0 | 32'h08, 32'h01);
    rd("rd status rise", A0 | 32'h1C, 32'h01);
    acc("clr status", A0 | 32'h1C, 4'b0001, 32'h01, 32'h01);
    cyc(1);
    pin("irq cleared", 32'(irq0), 0);
    rd("rd status clr", A0 | 32'h1C, 32'h0);

    // Edge on a channel with no enables sets nothing
    gpio_in0[1] = 1'b1;
    cyc(10);
    rd("status disabled", A0 | 32'h1C, 32'h0);
    rd("rd in 03", A0 | 32'h08, 32'h03);

    // Falling edge on channel 1
    acc("wr fall_en", A0 | 32'h18, 4'b0001, 32'h02, 32'h0);
    cyc(2);
    gpio_in0[1] = 1'b0;
    cyc(3);
    rd("in before latency", A0 | 32'h08, 32'h03);
    cyc(4);
    pin("irq fall", 32'(irq0), 1);
    rd("rd status fall", A0 | 32'h1C, 32'h02);
    rd("rd in fall", A0 | 32'h08, 32'h01);
    acc("fall_en off", A0 | 32'h18, 4'b0001, 32'h00, 32'h02);
    cyc(2);
    pin("irq masked", 32'(irq0), 0);
    rd("status kept", A0 | 32'h1C, 32'h02);
    acc("clr all", A0 | 32'h1C, 4'hF, 32'hFFFF_FFFF, 32'h02);
    rd("status zero", A0 | 32'h1C, 32'h0);

    // Prescaled debounce: glitch rejected, held level accepted
    acc("dut4 rise_en", A4 | 32'h14, 4'b0001, 32'h04, 32'h0);
    gpio_in4[2] = 1'b1;
    cyc(1);
    gpio_in4[2] = 1'b0;
    cyc(30);
    rd("dut4 in glitch", A4 | 32'h08, 32'h0);
    rd("dut4 status glitch", A4 | 32'h1C, 32'h0);
    pin("dut4 irq glitch", 32'(irq4), 0);
    cyc(2);
    gpio_in4[2] = 1'b1;
    cyc(9);
    rd("dut4 in early", A4 | 32'h08, 32'h0);
    cyc(5);
    rd("dut4 in held", A4 | 32'h08, 32'h04);
    rd("dut4 status held", A4 | 32'h1C, 32'h04);
    pin("dut4 irq held", 32'(irq4), 1);
    pin("dut0 idle during dut4", 32'(ready0), 0);

    // Reset during a select drops the access and clears everything
    rd("pre-reset out", A0 | 32'h00, 32'hAA);
    cyc(1);
    iomem_valid = 1'b1;
    iomem_addr  = A0;
    iomem_wstrb = 4'h0;
    resetn      = 1'b0;
    cyc(1);
    pin("rst no ready", 32'(ready0), 0);
    resetn      = 1'b1;
    iomem_valid = 1'b0;
    cyc(1);
    pin("rst no late ready", 32'(ready0), 0);
    pin("rst rdata clr", rdata0, 0);
    pin("rst out clr", 32'(out0), 0);
    pin("rst oe clr", 32'(oe0), 0);
    pin("rst pu clr", 32'(pu0), 0);
    pin("rst pd clr", 32'(pd0), 0);
    pin("dut4 irq clr", 32'(irq4), 0);
    cyc(10);
    rd("rst rd out", A0 | 32'h00, 32'h0);
    rd("rst rd rise_en", A0 | 32'h14, 32'h0);
    rd("rst rd status", A0 | 32'h1C, 32'h0);
    rd("rst rd pd", A0 | 32'h10, 32'h0);

    // Foreign base address never answered
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0300_0000;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      seen = seen | ready0 | ready4;
    end
    iomem_valid = 1'b0;
    pin("foreign base", 32'(seen), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
